// File: rtl/controladora_multiciclo.sv
// ============================================================================
// Module      : controladora_multiciclo
// Description : Multicycle MIPS main control FSM with memory-ready handshake,
//               illegal-opcode detection and a memory-wait watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controladora_multiciclo #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_pronto,
    output logic       IouD,
    output logic       LeMem,
    output logic       EscreveMem,
    output logic       EscreveIR,
    output logic       EscreveReg,
    output logic       EscrevePC,
    output logic       EscrevePCCond,
    output logic       BranchNe,
    output logic       ExtZero,
    output logic       OrigUlaA,
    output logic [1:0] RegDst,
    output logic [1:0] MemparaReg,
    output logic [1:0] OrigUlaB,
    output logic [1:0] OrigPC,
    output logic [2:0] OpULA,
    output logic [3:0] estado,
    output logic       instr_fim,
    output logic       excecao,
    output logic       erro_mem
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11,
        S_JAL      = 4'd12
    } estado_t;

    localparam logic [TIMEOUT_W-1:0] LIMITE = '1;

    estado_t              estado_q, estado_d;
    logic [5:0]           op_q;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 ready;
    logic                 mem_espera;
    logic                 timeout;

    assign ready      = (MEM_HANDSHAKE != 0) ? mem_pronto : 1'b1;
    assign mem_espera = (MEM_HANDSHAKE != 0) && !ready &&
                        (estado_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE});
    assign timeout    = mem_espera && (cnt_q == LIMITE);
    assign estado     = estado_q;

    always_comb begin
        estado_d      = estado_q;
        cnt_d         = (mem_espera && !timeout) ? cnt_q + 1'b1 : '0;
        IouD          = 1'b0;
        LeMem         = 1'b0;
        EscreveMem    = 1'b0;
        EscreveIR     = 1'b0;
        EscreveReg    = 1'b0;
        EscrevePC     = 1'b0;
        EscrevePCCond = 1'b0;
        BranchNe      = 1'b0;
        ExtZero       = 1'b0;
        OrigUlaA      = 1'b0;
        RegDst        = 2'b00;
        MemparaReg    = 2'b00;
        OrigUlaB      = 2'b00;
        OrigPC        = 2'b00;
        OpULA         = 3'b000;
        instr_fim     = 1'b0;
        excecao       = 1'b0;
        erro_mem      = 1'b0;

        case (estado_q)
            S_FETCH: begin
                LeMem    = 1'b1;
                OrigUlaB = 2'b01;
                if (timeout) begin
                    erro_mem = 1'b1;
                end else if (ready) begin
                    EscreveIR = 1'b1;
                    EscrevePC = 1'b1;
                    estado_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                OrigUlaB = 2'b11;
                case (Op)
                    6'b000000:                       estado_d = S_EXEC;
                    6'b100011, 6'b101011:            estado_d = S_MEMADR;
                    6'b000100, 6'b000101:            estado_d = S_BRANCH;
                    6'b000010:                       estado_d = S_JUMP;
                    6'b000011:                       estado_d = S_JAL;
                    6'b001000, 6'b001010, 6'b001100,
                    6'b001101, 6'b001110:            estado_d = S_IEXEC;
                    default: begin
                        excecao  = 1'b1;
                        estado_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                OrigUlaA = 1'b1;
                OrigUlaB = 2'b10;
                estado_d = (op_q == 6'b101011) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                LeMem = 1'b1;
                IouD  = 1'b1;
                if (timeout) begin
                    erro_mem = 1'b1;
                    estado_d = S_FETCH;
                end else if (ready) begin
                    estado_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                EscreveReg = 1'b1;
                MemparaReg = 2'b01;
                instr_fim  = 1'b1;
                estado_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                IouD = 1'b1;
                // An expired watchdog drops the pending store entirely.
                if (timeout) begin
                    erro_mem = 1'b1;
                    estado_d = S_FETCH;
                end else begin
                    EscreveMem = 1'b1;
                    if (ready) begin
                        instr_fim = 1'b1;
                        estado_d  = S_FETCH;
                    end
                end
            end
            S_EXEC: begin
                OrigUlaA = 1'b1;
                OpULA    = 3'b010;
                estado_d = S_RWB;
            end
            S_RWB: begin
                EscreveReg = 1'b1;
                RegDst     = 2'b01;
                instr_fim  = 1'b1;
                estado_d   = S_FETCH;
            end
            S_IEXEC: begin
                OrigUlaA = 1'b1;
                OrigUlaB = 2'b10;
                case (op_q)
                    6'b001010: OpULA = 3'b011;
                    6'b001100: begin OpULA = 3'b100; ExtZero = 1'b1; end
                    6'b001101: begin OpULA = 3'b101; ExtZero = 1'b1; end
                    6'b001110: begin OpULA = 3'b110; ExtZero = 1'b1; end
                    default:   OpULA = 3'b000;
                endcase
                estado_d = S_IWB;
            end
            S_IWB: begin
                EscreveReg = 1'b1;
                instr_fim  = 1'b1;
                estado_d   = S_FETCH;
            end
            S_BRANCH: begin
                OrigUlaA      = 1'b1;
                OpULA         = 3'b001;
                OrigPC        = 2'b01;
                EscrevePCCond = 1'b1;
                BranchNe      = (op_q == 6'b000101);
                instr_fim     = 1'b1;
                estado_d      = S_FETCH;
            end
            S_JUMP: begin
                OrigPC    = 2'b10;
                EscrevePC = 1'b1;
                instr_fim = 1'b1;
                estado_d  = S_FETCH;
            end
            S_JAL: begin
                EscreveReg = 1'b1;
                RegDst     = 2'b10;
                MemparaReg = 2'b10;
                OrigPC     = 2'b10;
                EscrevePC  = 1'b1;
                instr_fim  = 1'b1;
                estado_d   = S_FETCH;
            end
            default: estado_d = S_FETCH;
        endcase

        // Reset asserted: nothing may reach the datapath, even combinationally.
        if (!rst_n) begin
            IouD          = 1'b0;
            LeMem         = 1'b0;
            EscreveMem    = 1'b0;
            EscreveIR     = 1'b0;
            EscreveReg    = 1'b0;
            EscrevePC     = 1'b0;
            EscrevePCCond = 1'b0;
            BranchNe      = 1'b0;
            ExtZero       = 1'b0;
            OrigUlaA      = 1'b0;
            RegDst        = 2'b00;
            MemparaReg    = 2'b00;
            OrigUlaB      = 2'b00;
            OrigPC        = 2'b00;
            OpULA         = 3'b000;
            instr_fim     = 1'b0;
            excecao       = 1'b0;
            erro_mem      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= S_FETCH;
            op_q     <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            if (estado_q == S_DECODE) begin
                op_q <= Op;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controladora_multiciclo.sv
// ============================================================================
// Module      : tb_controladora_multiciclo
// Description : Directed bench for controladora_multiciclo over three configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controladora_multiciclo;

    // Control bundle layout: {IouD,LeMem,EscreveMem,EscreveIR,EscreveReg,
    // EscrevePC,EscrevePCCond,BranchNe,ExtZero,OrigUlaA,RegDst,MemparaReg,
    // OrigUlaB,OrigPC,OpULA,instr_fim,excecao,erro_mem}
    localparam logic [23:0] C_IOUD   = 24'h800000;
    localparam logic [23:0] C_LEMEM  = 24'h400000;
    localparam logic [23:0] C_ESCMEM = 24'h200000;
    localparam logic [23:0] C_ESCIR  = 24'h100000;
    localparam logic [23:0] C_ESCREG = 24'h080000;
    localparam logic [23:0] C_ESCPC  = 24'h040000;
    localparam logic [23:0] C_PCCOND = 24'h020000;
    localparam logic [23:0] C_BNE    = 24'h010000;
    localparam logic [23:0] C_EXTZ   = 24'h008000;
    localparam logic [23:0] C_ULAA   = 24'h004000;
    localparam logic [23:0] C_RD01   = 24'h001000;
    localparam logic [23:0] C_RD10   = 24'h002000;
    localparam logic [23:0] C_MR01   = 24'h000400;
    localparam logic [23:0] C_MR10   = 24'h000800;
    localparam logic [23:0] C_UB01   = 24'h000100;
    localparam logic [23:0] C_UB10   = 24'h000200;
    localparam logic [23:0] C_UB11   = 24'h000300;
    localparam logic [23:0] C_PC01   = 24'h000040;
    localparam logic [23:0] C_PC10   = 24'h000080;
    localparam logic [23:0] C_SUB    = 24'h000008;
    localparam logic [23:0] C_FUNCT  = 24'h000010;
    localparam logic [23:0] C_SLT    = 24'h000018;
    localparam logic [23:0] C_OR     = 24'h000028;
    localparam logic [23:0] C_FIM    = 24'h000004;
    localparam logic [23:0] C_EXC    = 24'h000002;
    localparam logic [23:0] C_ERR    = 24'h000001;

    localparam logic [23:0] V_FETCH_R = C_LEMEM | C_UB01 | C_ESCIR | C_ESCPC;
    localparam logic [23:0] V_FETCH_W = C_LEMEM | C_UB01;
    localparam logic [23:0] V_DECODE  = C_UB11;
    localparam logic [23:0] V_MEMADR  = C_ULAA | C_UB10;
    localparam logic [23:0] V_MEMREAD = C_LEMEM | C_IOUD;
    localparam logic [23:0] V_MEMWB   = C_ESCREG | C_MR01 | C_FIM;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op_a  [3];
    logic        mp_a  [3];
    logic [23:0] ctl   [3];
    logic [3:0]  est   [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // 0: default config, 1: short watchdog, 2: handshake disabled
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       iou, lem, escm, escir, escr, escpc, pccond, bne, extz, ulaa;
        logic [1:0] rd, mr, ub, opc;
        logic [2:0] opula;
        logic [3:0] st;
        logic       fim, exc, err;

        controladora_multiciclo #(
            .MEM_HANDSHAKE((g == 2) ? 0 : 1),
            .TIMEOUT_W    ((g == 1) ? 2 : 4)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .Op           (op_a[g]),
            .mem_pronto   (mp_a[g]),
            .IouD         (iou),
            .LeMem        (lem),
            .EscreveMem   (escm),
            .EscreveIR    (escir),
            .EscreveReg   (escr),
            .EscrevePC    (escpc),
            .EscrevePCCond(pccond),
            .BranchNe     (bne),
            .ExtZero      (extz),
            .OrigUlaA     (ulaa),
            .RegDst       (rd),
            .MemparaReg   (mr),
            .OrigUlaB     (ub),
            .OrigPC       (opc),
            .OpULA        (opula),
            .estado       (st),
            .instr_fim    (fim),
            .excecao      (exc),
            .erro_mem     (err)
        );

        assign ctl[g] = {iou, lem, escm, escir, escr, escpc, pccond, bne, extz, ulaa,
                         rd, mr, ub, opc, opula, fim, exc, err};
        assign est[g] = st;
    end

    task automatic chk_now(input int d, input logic [3:0] est_e, input logic [23:0] ctl_e,
                           input string tag);
        checks++;
        assert (est[d] === est_e) else begin
            errors++;
            $error("FAIL %s estado: got %0d expected %0d", tag, est[d], est_e);
        end
        checks++;
        assert (ctl[d] === ctl_e) else begin
            errors++;
            $error("FAIL %s controls: got %h expected %h", tag, ctl[d], ctl_e);
        end
    endtask

    // Check the current cycle at the falling edge, then step to just past the next rising edge.
    task automatic chk(input int d, input logic [3:0] est_e, input logic [23:0] ctl_e,
                       input string tag);
        @(negedge clk);
        chk_now(d, est_e, ctl_e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_a[i] = 6'b000000;
            mp_a[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_now(0, 4'd0, 24'h0, "reset_held");
        rst_n = 1'b1;

        // R-type: 0,1,6,7
        chk(0, 4'd0, V_FETCH_R, "r_fetch");
        chk(0, 4'd1, V_DECODE, "r_decode");
        chk(0, 4'd6, C_ULAA | C_FUNCT, "r_exec");
        chk(0, 4'd7, C_ESCREG | C_RD01 | C_FIM, "r_rwb");

        // lw with two wait cycles in MEMREAD
        op_a[0] = 6'b100011;
        chk(0, 4'd0, V_FETCH_R, "lw_fetch");
        chk(0, 4'd1, V_DECODE, "lw_decode");
        chk(0, 4'd2, V_MEMADR, "lw_memadr");
        mp_a[0] = 1'b0;
        chk(0, 4'd3, V_MEMREAD, "lw_wait1");
        chk(0, 4'd3, V_MEMREAD, "lw_wait2");
        mp_a[0] = 1'b1;
        chk(0, 4'd3, V_MEMREAD, "lw_ready");
        chk(0, 4'd4, V_MEMWB, "lw_memwb");

        // bne, opcode input changed after DECODE
        op_a[0] = 6'b000101;
        chk(0, 4'd0, V_FETCH_R, "bne_fetch");
        chk(0, 4'd1, V_DECODE, "bne_decode");
        op_a[0] = 6'b000000;
        chk(0, 4'd8, C_ULAA | C_SUB | C_PC01 | C_PCCOND | C_BNE | C_FIM, "bne_branch");

        op_a[0] = 6'b000100;
        chk(0, 4'd0, V_FETCH_R, "beq_fetch");
        chk(0, 4'd1, V_DECODE, "beq_decode");
        chk(0, 4'd8, C_ULAA | C_SUB | C_PC01 | C_PCCOND | C_FIM, "beq_branch");

        op_a[0] = 6'b000011;
        chk(0, 4'd0, V_FETCH_R, "jal_fetch");
        chk(0, 4'd1, V_DECODE, "jal_decode");
        chk(0, 4'd12, C_ESCREG | C_RD10 | C_MR10 | C_PC10 | C_ESCPC | C_FIM, "jal");

        op_a[0] = 6'b000010;
        chk(0, 4'd0, V_FETCH_R, "j_fetch");
        chk(0, 4'd1, V_DECODE, "j_decode");
        chk(0, 4'd9, C_PC10 | C_ESCPC | C_FIM, "jump");

        // ori, opcode changed to addi after DECODE; op_reg must win
        op_a[0] = 6'b001101;
        chk(0, 4'd0, V_FETCH_R, "ori_fetch");
        chk(0, 4'd1, V_DECODE, "ori_decode");
        op_a[0] = 6'b001000;
        chk(0, 4'd10, C_ULAA | C_UB10 | C_OR | C_EXTZ, "ori_iexec");
        chk(0, 4'd11, C_ESCREG | C_FIM, "ori_iwb");

        op_a[0] = 6'b001010;
        chk(0, 4'd0, V_FETCH_R, "slti_fetch");
        chk(0, 4'd1, V_DECODE, "slti_decode");
        chk(0, 4'd10, C_ULAA | C_UB10 | C_SLT, "slti_iexec");
        chk(0, 4'd11, C_ESCREG | C_FIM, "slti_iwb");

        // Illegal opcode
        op_a[0] = 6'b111111;
        chk(0, 4'd0, V_FETCH_R, "ill_fetch");
        chk(0, 4'd1, V_DECODE | C_EXC, "ill_decode");

        // sw without wait, entered after a FETCH stall
        op_a[0] = 6'b101011;
        mp_a[0] = 1'b0;
        chk(0, 4'd0, V_FETCH_W, "sw_fetch_wait");
        mp_a[0] = 1'b1;
        chk(0, 4'd0, V_FETCH_R, "sw_fetch");
        chk(0, 4'd1, V_DECODE, "sw_decode");
        chk(0, 4'd2, V_MEMADR, "sw_memadr");
        chk(0, 4'd5, C_ESCMEM | C_IOUD | C_FIM, "sw_memwrite");

        // Reset asserted in the middle of MEMWB
        op_a[0] = 6'b100011;
        chk(0, 4'd0, V_FETCH_R, "rst_fetch");
        chk(0, 4'd1, V_DECODE, "rst_decode");
        chk(0, 4'd2, V_MEMADR, "rst_memadr");
        chk(0, 4'd3, V_MEMREAD, "rst_memread");
        #1;
        chk_now(0, 4'd4, V_MEMWB, "rst_memwb");
        rst_n = 1'b0;
        #1;
        chk_now(0, 4'd0, 24'h0, "rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_a[0] = 6'b000000;
        chk(0, 4'd0, V_FETCH_R, "rst_refetch");

        // Watchdog: TIMEOUT_W=2, store never acknowledged
        reset_all();
        op_a[1] = 6'b101011;
        chk(1, 4'd0, V_FETCH_R, "wd_fetch");
        chk(1, 4'd1, V_DECODE, "wd_decode");
        chk(1, 4'd2, V_MEMADR, "wd_memadr");
        mp_a[1] = 1'b0;
        chk(1, 4'd5, C_ESCMEM | C_IOUD, "wd_wait1");
        chk(1, 4'd5, C_ESCMEM | C_IOUD, "wd_wait2");
        chk(1, 4'd5, C_ESCMEM | C_IOUD, "wd_wait3");
        chk(1, 4'd5, C_IOUD | C_ERR, "wd_timeout");
        chk(1, 4'd0, V_FETCH_W, "wd_after");
        mp_a[1] = 1'b1;
        chk(1, 4'd0, V_FETCH_R, "wd_recover");

        // Handshake disabled: mem_pronto low is ignored, lw in 5 cycles
        reset_all();
        op_a[2] = 6'b100011;
        mp_a[2] = 1'b0;
        chk(2, 4'd0, V_FETCH_R, "nh_fetch");
        chk(2, 4'd1, V_DECODE, "nh_decode");
        chk(2, 4'd2, V_MEMADR, "nh_memadr");
        chk(2, 4'd3, V_MEMREAD, "nh_memread");
        chk(2, 4'd4, V_MEMWB, "nh_memwb");
        chk(2, 4'd0, V_FETCH_R, "nh_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controladora_multiciclo.md
# controladora_multiciclo

Multicycle main control FSM for the MIPS datapath: the next-generation replacement for the single-cycle opcode decoder. Sequences each instruction through fetch/decode/execute/memory/writeback states, drives all datapath enables and mux selects, waits on a memory-ready handshake, and flags illegal opcodes and memory timeouts. Sits between the instruction register's opcode field, the shared instruction/data memory and the multicycle datapath.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_pronto; 0 = mem_pronto ignored, memory states take 1 cycle.
- TIMEOUT_W, 4: width of memory-wait watchdog; limit = 2^TIMEOUT_W-1 cycles.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Op  in  6  opcode from instruction register.
- mem_pronto  in  1  memory ready for current access.
- IouD, LeMem, EscreveMem, EscreveIR, EscreveReg, EscrevePC, EscrevePCCond, BranchNe, ExtZero, OrigUlaA  out  1 each  datapath controls.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemparaReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- OrigUlaB  out  2  00 B, 01 const 4, 10 ext imm, 11 sext imm<<2.
- OrigPC  out  2  00 ALU, 01 ALUOut, 10 jump target.
- OpULA  out  3  000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or, 110 xor.
- estado  out  4  current state (debug).
- instr_fim, excecao, erro_mem  out  1 each  one-cycle status pulses.

## Operation
- States (estado code): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JAL 12. Codes 13-15 -> FETCH next cycle, no writes.
- Outputs are functions of state (plus latched opcode and mem_pronto); unlisted outputs 0.
- FETCH: LeMem, OrigUlaB=01, OpULA=000; EscreveIR=EscrevePC=ready. Advance to DECODE when ready.
- DECODE: OrigUlaB=11, OpULA=000; latch Op into op_reg. Next: 000000 EXEC; 100011/101011 MEMADR; 000100/000101 BRANCH; 000010 JUMP; 000011 JAL; 001000/001010/001100/001101/001110 IEXEC; anything else -> excecao pulse, FETCH.
- MEMADR: OrigUlaA, OrigUlaB=10 -> MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: LeMem, IouD; -> MEMWB when ready. MEMWB: EscreveReg, MemparaReg=01.
- MEMWRITE: EscreveMem, IouD held until ready; -> FETCH.
- EXEC: OrigUlaA, OpULA=010 -> RWB: EscreveReg, RegDst=01.
- IEXEC: OrigUlaA, OrigUlaB=10; OpULA addi 000, slti 011, andi 100, ori 101, xori 110; ExtZero for andi/ori/xori -> IWB: EscreveReg.
- BRANCH: OrigUlaA, OpULA=001, OrigPC=01, EscrevePCCond, BranchNe=(op_reg==000101).
- JUMP: OrigPC=10, EscrevePC. JAL: EscreveReg, RegDst=10, MemparaReg=10, OrigPC=10, EscrevePC.
- ready = mem_pronto when MEM_HANDSHAKE=1, else 1.
- instr_fim: asserted in MEMWB, RWB, IWB, BRANCH, JUMP, JAL, and MEMWRITE when ready.
- Watchdog: counter increments each cycle in FETCH/MEMREAD/MEMWRITE with ready=0, clears on ready or state change. Reaching limit: erro_mem pulse, counter cleared, -> FETCH, no writes that cycle (EscreveMem forced 0). Disabled when MEM_HANDSHAKE=0.

## Timing
- rst_n low: state=FETCH, op_reg=0, counter=0 asynchronously; all outputs forced 0 while low. First FETCH after release.
- Cycles (no wait): R/I-imm/sw 4, lw 5, beq/bne/j/jal 3. Each wait cycle adds 1.
- mem_pronto sampled on the same edge it enables; ready in the first FETCH cycle gives EscreveIR/EscrevePC that cycle.
- Reset mid-instruction aborts immediately; no partial write after rst_n low.
- Op changes after DECODE do not affect BRANCH/IEXEC decoding (op_reg used).

## Test plan
- Reset, MEM_HANDSHAKE=1, mem_pronto=1, Op=000000 -> estado 0,1,6,7,0; EscreveReg=1 RegDst=01 in state 7; instr_fim once.
- Op=100011, mem_pronto low 2 cycles in MEMREAD -> estado 0,1,2,3,3,3,4,0; MemparaReg=01 in 4.
- Op=000101 -> BRANCH with BranchNe=1, OpULA=001, EscrevePCCond=1; Op=000011 -> JAL with RegDst=10, MemparaReg=10, EscrevePC=1.
- Op=111111 -> excecao pulse in DECODE, next estado 0, no write enable asserted.
- TIMEOUT_W=2, mem_pronto stuck 0 in MEMWRITE -> erro_mem after 3 wait cycles, EscreveMem=0 that cycle, estado 0.
- rst_n pulsed low during MEMWB -> all outputs 0 immediately, estado 0; MEM_HANDSHAKE=0 with mem_pronto=0 -> lw completes in 5 cycles.
